dcache_wbuf: RTL and testbench

//   Parametrised write buffer between the dcache and the AXI write master; generalises the dcache FIFO.

---
 rtl/dcache_wbuf.sv | 169 ++++++++++++++++
 tb/tb_dcache_wbuf.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/dcache_wbuf.sv
// rtl/dcache_wbuf.sv - dcache write buffer with byte merge, read forwarding and AXI drain
//
// Purpose: a circular FIFO of dirty lines between the dcache and the AXI write
// master. CPU writes merge into resident lines that are not in flight, or
// allocate at the tail. Lookups are forwarded from the youngest matching entry.
// The head entry drains over a ready/valid request followed by a write response.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cpu_wreq_i/awaddr/wdata/wstrb, cpu_wready_o     CPU line write (combinational ready)
//   cpu_rreq_i/araddr, read_hit_o/cpu_rdata_o/cpu_rstrb_o   lookup, registered result
//   axi_wen_o/awaddr/wdata/wstrb, axi_wready_i, axi_bvalid_i   drain of head entry
//   count_o                  number of valid entries
//   state                    {full, empty}
module dcache_wbuf #(
  parameter int DEPTH      = 4,
  parameter int LINE_WIDTH = 128,
  parameter int ADDR_WIDTH = 32,
  parameter int OFF_BITS   = $clog2(LINE_WIDTH/8)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cpu_wreq_i,
  input  logic [ADDR_WIDTH-1:0]      cpu_awaddr_i,
  input  logic [LINE_WIDTH-1:0]      cpu_wdata_i,
  input  logic [LINE_WIDTH/8-1:0]    cpu_wstrb_i,
  output logic                       cpu_wready_o,
  input  logic                       cpu_rreq_i,
  input  logic [ADDR_WIDTH-1:0]      cpu_araddr_i,
  output logic                       read_hit_o,
  output logic [LINE_WIDTH-1:0]      cpu_rdata_o,
  output logic [LINE_WIDTH/8-1:0]    cpu_rstrb_o,
  output logic                       axi_wen_o,
  output logic [ADDR_WIDTH-1:0]      axi_awaddr_o,
  output logic [LINE_WIDTH-1:0]      axi_wdata_o,
  output logic [LINE_WIDTH/8-1:0]    axi_wstrb_o,
  input  logic                       axi_wready_i,
  input  logic                       axi_bvalid_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [1:0]                 state
);

  localparam int NB = LINE_WIDTH/8;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = ADDR_WIDTH - OFF_BITS;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_B} drain_t;
  drain_t st_q, st_d;

  logic [DEPTH-1:0]      valid_q;
  logic [TW-1:0]         tag_q  [DEPTH];
  logic [LINE_WIDTH-1:0] data_q [DEPTH];
  logic [NB-1:0]         strb_q [DEPTH];
  logic [PW-1:0]         head_q, tail_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, empty_q;

  logic [TW-1:0] wtag, rtag;
  logic          whit, rhit;
  logic [PW-1:0] whit_idx, ridx;
  logic          wr_acc, alloc, merge, pop;

  // Offset bits never take part in a line compare.
  logic unused_off;
  assign unused_off = ^{cpu_awaddr_i[OFF_BITS-1:0], cpu_araddr_i[OFF_BITS-1:0]};

  assign wtag = cpu_awaddr_i[ADDR_WIDTH-1:OFF_BITS];
  assign rtag = cpu_araddr_i[ADDR_WIDTH-1:OFF_BITS];

  // The head is frozen once the drain FSM leaves IDLE, so it cannot be a write hit.
  always_comb begin
    whit     = 1'b0;
    whit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && tag_q[i] == wtag &&
          !(st_q != S_IDLE && head_q == PW'(i))) begin
        whit     = 1'b1;
        whit_idx = PW'(i);
      end
    end
  end

  // Valid entries are contiguous from head, so scanning head->tail and keeping
  // the last match selects the youngest copy of the line.
  always_comb begin
    logic [PW-1:0] idx;
    rhit = 1'b0;
    ridx = '0;
    idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (valid_q[idx] && tag_q[idx] == rtag) begin
        rhit = 1'b1;
        ridx = idx;
      end
    end
  end

  // Ready uses the registered full flag, so a same-cycle pop cannot open it.
  assign cpu_wready_o = whit || !full_q;
  assign wr_acc       = cpu_wreq_i && cpu_wready_o;
  assign alloc        = wr_acc && !whit;
  assign merge        = wr_acc && whit;
  assign pop          = (st_q == S_WAIT_B) && axi_bvalid_i;
  assign count_d      = count_q + CW'(alloc) - CW'(pop);

  always_comb begin
    st_d      = st_q;
    axi_wen_o = 1'b0;
    unique case (st_q)
      S_IDLE:   if (!empty_q) st_d = S_REQ;
      S_REQ: begin
        axi_wen_o = 1'b1;
        if (axi_wready_i) st_d = S_WAIT_B;
      end
      S_WAIT_B: if (axi_bvalid_i) st_d = S_IDLE;
      default:  st_d = S_IDLE;
    endcase
  end

  assign axi_awaddr_o = {tag_q[head_q], {OFF_BITS{1'b0}}};
  assign axi_wdata_o  = data_q[head_q];
  assign axi_wstrb_o  = strb_q[head_q];
  assign count_o      = count_q;
  assign state        = {full_q, empty_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= S_IDLE;
      valid_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      read_hit_o  <= 1'b0;
      cpu_rdata_o <= '0;
      cpu_rstrb_o <= '0;
    end else begin
      st_q <= st_d;
      if (alloc) begin
        valid_q[tail_q] <= 1'b1;
        tag_q[tail_q]   <= wtag;
        data_q[tail_q]  <= cpu_wdata_i;
        strb_q[tail_q]  <= cpu_wstrb_i;
        tail_q          <= tail_q + 1'b1;
      end
      if (merge) begin
        for (int b = 0; b < NB; b++) begin
          if (cpu_wstrb_i[b]) data_q[whit_idx][b*8 +: 8] <= cpu_wdata_i[b*8 +: 8];
        end
        strb_q[whit_idx] <= strb_q[whit_idx] | cpu_wstrb_i;
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
      // Lookup samples contents before any same-cycle write lands.
      read_hit_o  <= cpu_rreq_i && rhit;
      cpu_rdata_o <= (cpu_rreq_i && rhit) ? data_q[ridx] : '0;
      cpu_rstrb_o <= (cpu_rreq_i && rhit) ? strb_q[ridx] : '0;
    end
  end

endmodule

// File: tb/tb_dcache_wbuf.sv
// tb/tb_dcache_wbuf.sv - directed self-checking bench for dcache_wbuf
//
// Purpose: drives hand-built write/read/drain sequences and compares every
// observed output against hand-computed values.
// Ports: none (top-level bench).
module tb_dcache_wbuf;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_wreq_i;
  logic [31:0]  cpu_awaddr_i;
  logic [127:0] cpu_wdata_i;
  logic [15:0]  cpu_wstrb_i;
  logic         cpu_wready_o;
  logic         cpu_rreq_i;
  logic [31:0]  cpu_araddr_i;
  logic         read_hit_o;
  logic [127:0] cpu_rdata_o;
  logic [15:0]  cpu_rstrb_o;
  logic         axi_wen_o;
  logic [31:0]  axi_awaddr_o;
  logic [127:0] axi_wdata_o;
  logic [15:0]  axi_wstrb_o;
  logic         axi_wready_i;
  logic         axi_bvalid_i;
  logic [2:0]   count_o;
  logic [1:0]   state;

  int n_cmp = 0;
  int n_err = 0;

  dcache_wbuf dut (
    .clk(clk), .rst(rst),
    .cpu_wreq_i(cpu_wreq_i), .cpu_awaddr_i(cpu_awaddr_i), .cpu_wdata_i(cpu_wdata_i),
    .cpu_wstrb_i(cpu_wstrb_i), .cpu_wready_o(cpu_wready_o),
    .cpu_rreq_i(cpu_rreq_i), .cpu_araddr_i(cpu_araddr_i),
    .read_hit_o(read_hit_o), .cpu_rdata_o(cpu_rdata_o), .cpu_rstrb_o(cpu_rstrb_o),
    .axi_wen_o(axi_wen_o), .axi_awaddr_o(axi_awaddr_o), .axi_wdata_o(axi_wdata_o),
    .axi_wstrb_o(axi_wstrb_o), .axi_wready_i(axi_wready_i), .axi_bvalid_i(axi_bvalid_i),
    .count_o(count_o), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_wr(input logic [31:0] a, input logic [127:0] d, input logic [15:0] s);
    cpu_wreq_i   = 1'b1;
    cpu_awaddr_i = a;
    cpu_wdata_i  = d;
    cpu_wstrb_i  = s;
    #1;
  endtask

  task automatic set_rd(input logic [31:0] a);
    cpu_rreq_i   = 1'b1;
    cpu_araddr_i = a;
    #1;
  endtask

  task automatic clr();
    cpu_wreq_i = 1'b0;
    cpu_rreq_i = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; cpu_wreq_i = 1'b0; cpu_awaddr_i = '0; cpu_wdata_i = '0; cpu_wstrb_i = '0;
    cpu_rreq_i = 1'b0; cpu_araddr_i = '0; axi_wready_i = 1'b0; axi_bvalid_i = 1'b0;
    tick(); tick();
    check("rst_count", 128'(count_o), 128'd0);
    check("rst_state", 128'(state), 128'd1);
    check("rst_wen", 128'(axi_wen_o), 128'd0);
    check("rst_hit", 128'(read_hit_o), 128'd0);
    check("rst_rdata", cpu_rdata_o, 128'd0);
    check("rst_rstrb", 128'(cpu_rstrb_o), 128'd0);
    rst = 1'b0;

    // 1: single write, head goes to REQ
    set_wr(32'h1000, {16{8'hD1}}, 16'hFFFF); tick(); clr();
    check("t1_count", 128'(count_o), 128'd1);
    check("t1_state", 128'(state), 128'd0);
    tick();
    check("t1_wen", 128'(axi_wen_o), 128'd1);
    check("t1_awaddr", 128'(axi_awaddr_o), 128'h1000);
    check("t1_wdata", axi_wdata_o, {16{8'hD1}});

    // 2: merge two partial writes to one line
    set_wr(32'h2000, {16{8'hA1}}, 16'h000F); tick();
    set_wr(32'h2004, {16{8'hB2}}, 16'h00F0); tick(); clr();
    check("t2_count", 128'(count_o), 128'd2);
    set_rd(32'h2000); tick(); clr();
    check("t2_hit", 128'(read_hit_o), 128'd1);
    check("t2_rstrb", 128'(cpu_rstrb_o), 128'h00FF);
    check("t2_rdata", cpu_rdata_o, 128'hA1A1A1A1_A1A1A1A1_B2B2B2B2_A1A1A1A1);

    // 3: fill, full behaviour, hit on non-head line
    set_wr(32'h3000, {16{8'h33}}, 16'h0F00); tick();
    set_wr(32'h4000, {16{8'h44}}, 16'hFFFF); tick(); clr();
    check("t3_count", 128'(count_o), 128'd4);
    check("t3_state", 128'(state), 128'd2);
    set_wr(32'h5000, {16{8'h55}}, 16'hFFFF);
    check("t3_miss_ready", 128'(cpu_wready_o), 128'd0);
    set_wr(32'h1000, {16{8'h11}}, 16'hFFFF);
    check("t3_inflight_ready", 128'(cpu_wready_o), 128'd0);
    set_wr(32'h3008, {16{8'h77}}, 16'h0001);
    check("t3_hit_ready", 128'(cpu_wready_o), 128'd1);
    tick(); clr();
    check("t3_hit_count", 128'(count_o), 128'd4);
    set_rd(32'h3000); tick(); clr();
    check("t3_rdata", cpu_rdata_o, 128'h33333333_33333333_33333333_33333377);
    check("t3_rstrb", 128'(cpu_rstrb_o), 128'h0F01);

    // drain head; a pop does not open the write port in the same cycle
    axi_wready_i = 1'b1; tick(); axi_wready_i = 1'b0; #1;
    check("drain_wen_wait", 128'(axi_wen_o), 128'd0);
    axi_bvalid_i = 1'b1;
    set_wr(32'h5000, {16{8'h55}}, 16'hFFFF);
    check("pop_ready", 128'(cpu_wready_o), 128'd0);
    tick(); axi_bvalid_i = 1'b0; clr();
    check("pop_count", 128'(count_o), 128'd3);
    check("pop_state", 128'(state), 128'd0);
    check("pop_idle_wen", 128'(axi_wen_o), 128'd0);
    tick();
    check("next_wen", 128'(axi_wen_o), 128'd1);
    check("next_awaddr", 128'(axi_awaddr_o), 128'h2000);
    check("next_wstrb", 128'(axi_wstrb_o), 128'h00FF);

    // 6: reset while in REQ with 3 entries
    rst = 1'b1; tick(); rst = 1'b0;
    check("t6_count", 128'(count_o), 128'd0);
    check("t6_wen", 128'(axi_wen_o), 128'd0);
    check("t6_state", 128'(state), 128'd1);

    // 4: write to a line that is waiting for its response
    set_wr(32'h3000, {16{8'hC1}}, 16'hFFFF); tick(); clr();
    tick();
    check("t4_req", 128'(axi_wen_o), 128'd1);
    axi_wready_i = 1'b1; tick(); axi_wready_i = 1'b0; #1;
    set_wr(32'h3000, {16{8'hC2}}, 16'h00FF);
    check("t4_ready", 128'(cpu_wready_o), 128'd1);
    tick(); clr();
    check("t4_count", 128'(count_o), 128'd2);
    set_rd(32'h3000); tick(); clr();
    check("t4_hit", 128'(read_hit_o), 128'd1);
    check("t4_rdata", cpu_rdata_o, {16{8'hC2}});
    check("t4_rstrb", 128'(cpu_rstrb_o), 128'h00FF);
    axi_bvalid_i = 1'b1; tick(); axi_bvalid_i = 1'b0; #1;
    check("t4_pop_count", 128'(count_o), 128'd1);
    tick();
    check("t4_awaddr", 128'(axi_awaddr_o), 128'h3000);
    check("t4_wdata", axi_wdata_o, {16{8'hC2}});

    // 5: read concurrent with a merging write
    set_wr(32'h1000, {16{8'hE1}}, 16'hFFFF); tick(); clr();
    check("t5_count", 128'(count_o), 128'd2);
    set_wr(32'h1000, {16{8'hF2}}, 16'h000F);
    set_rd(32'h1000);
    check("t5_ready", 128'(cpu_wready_o), 128'd1);
    tick(); clr();
    check("t5_hit", 128'(read_hit_o), 128'd1);
    check("t5_pre_data", cpu_rdata_o, {16{8'hE1}});
    set_rd(32'h1000); tick(); clr();
    check("t5_post_data", cpu_rdata_o, 128'hE1E1E1E1_E1E1E1E1_E1E1E1E1_F2F2F2F2);
    check("t5_post_strb", 128'(cpu_rstrb_o), 128'hFFFF);
    tick();
    check("t5_norreq_hit", 128'(read_hit_o), 128'd0);
    set_rd(32'h9000); tick(); clr();
    check("t5_miss_hit", 128'(read_hit_o), 128'd0);
    check("t5_miss_count", 128'(count_o), 128'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
